// File: rtl/l2_write_buffer_if.sv
// L1-side request/response and L2-side transaction signals of the posted write buffer.
// The slave modport is the buffer's view; the master modport is the view of the surrounding L1/L2 environment.
interface l2_write_buffer_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          up_en;
  logic          up_wr_en;
  logic [AW-1:0] up_addr;
  logic [DW-1:0] up_wr_data;
  logic [DW-1:0] up_rd_data;
  logic          up_rd_valid;
  logic          up_stall;
  logic          l2_req;
  logic          l2_we;
  logic [AW-1:0] l2_addr;
  logic [DW-1:0] l2_wdata;
  logic [DW-1:0] l2_rdata;
  logic          l2_ack;
  logic [CW-1:0] wb_count;

  modport master (
    output up_en, up_wr_en, up_addr, up_wr_data, l2_rdata, l2_ack,
    input  up_rd_data, up_rd_valid, up_stall, l2_req, l2_we, l2_addr, l2_wdata, wb_count
  );

  modport slave (
    input  up_en, up_wr_en, up_addr, up_wr_data, l2_rdata, l2_ack,
    output up_rd_data, up_rd_valid, up_stall, l2_req, l2_we, l2_addr, l2_wdata, wb_count
  );
endinterface

// File: rtl/l2_write_buffer.sv
// Posted write buffer between the L1 dcache and L2: queues stores, drains them in order, gives reads priority.
// Optional macro WB_RAW_FWD_EN: forward read-after-write hits from the youngest queued store instead of draining.
module l2_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input logic             clk,
  input logic             rst,
  l2_write_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, READ, RDONE, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          l2_req_q, l2_we_q, rd_valid_q;
  logic [AW-1:0] l2_addr_q;
  logic [DW-1:0] l2_wdata_q, rd_data_q;
  logic          full, rd_req, enq, deq, hazard, ld_rd, ld_dr, rd_stall;

  assign full   = (count_q == CW'(DEPTH));
  assign rd_req = bus.up_en & ~bus.up_wr_en;
  assign enq    = bus.up_en & bus.up_wr_en & ~full;

  always_comb begin : hazard_scan
    logic [PW-1:0] idx;
    hazard = 1'b0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if ((CW'(k) < count_q) && (addr_q[idx] == bus.up_addr)) hazard = 1'b1;
    end
  end

  // Reads win only at the IDLE decision; a presented drain always runs to its ack.
  always_comb begin
    state_d = state_q;
    deq     = 1'b0;
    ld_rd   = 1'b0;
    ld_dr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_req && !hazard) begin
          state_d = READ;
          ld_rd   = 1'b1;
        end else if (count_q != '0) begin
          state_d = DRAIN;
          ld_dr   = 1'b1;
        end
      end
      READ:  if (bus.l2_ack) state_d = RDONE;
      RDONE: state_d = IDLE;
      DRAIN: begin
        if (bus.l2_ack) begin
          state_d = IDLE;
          deq     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[wr_ptr_q] <= bus.up_addr;
      data_q[wr_ptr_q] <= bus.up_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q  <= count_q + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l2_req_q   <= 1'b0;
      l2_we_q    <= 1'b0;
      l2_addr_q  <= '0;
      l2_wdata_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= (state_q == READ) && bus.l2_ack;
      if ((state_q == READ) && bus.l2_ack) rd_data_q <= bus.l2_rdata;
      if (ld_rd) begin
        l2_req_q  <= 1'b1;
        l2_we_q   <= 1'b0;
        l2_addr_q <= bus.up_addr;
      end else if (ld_dr) begin
        l2_req_q   <= 1'b1;
        l2_we_q    <= 1'b1;
        l2_addr_q  <= addr_q[rd_ptr_q];
        l2_wdata_q <= data_q[rd_ptr_q];
      end else if (((state_q == READ) || (state_q == DRAIN)) && bus.l2_ack) begin
        l2_req_q <= 1'b0;
      end
    end
  end

`ifdef WB_RAW_FWD_EN
  logic [DW-1:0] fwd_data;

  // Scan oldest to youngest so the last match (youngest store) wins.
  always_comb begin : fwd_scan
    logic [PW-1:0] idx;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if ((CW'(k) < count_q) && (addr_q[idx] == bus.up_addr)) fwd_data = data_q[idx];
    end
  end

  assign rd_stall        = rd_req & ~hazard & (state_q != RDONE);
  assign bus.up_rd_valid = rd_valid_q | (rd_req & hazard);
  assign bus.up_rd_data  = (rd_req & hazard) ? fwd_data : rd_data_q;
`else
  assign rd_stall        = rd_req & (state_q != RDONE);
  assign bus.up_rd_valid = rd_valid_q;
  assign bus.up_rd_data  = rd_data_q;
`endif

  assign bus.up_stall = rd_stall | (bus.up_en & bus.up_wr_en & full);
  assign bus.l2_req   = l2_req_q;
  assign bus.l2_we    = l2_we_q;
  assign bus.l2_addr  = l2_addr_q;
  assign bus.l2_wdata = l2_wdata_q;
  assign bus.wb_count = count_q;
endmodule

// File: tb/tb_l2_write_buffer.sv
// Directed bench for l2_write_buffer: vector table for store/read/full cases, hand sequences for RAW and reset.
module tb_l2_write_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  l2_write_buffer_if #(.DEPTH(4), .AW(32), .DW(32)) bus ();

  l2_write_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        en, we;
    logic [31:0] addr, wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        x_stall, x_req, x_we;
    logic [31:0] x_addr, x_wdata;
    logic [2:0]  x_cnt;
    logic        x_rv;
    logic [31:0] x_rdata;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic en, we, input logic [31:0] a, d, input logic ack,
                              input logic [31:0] rd, input logic xs, xr, xw,
                              input logic [31:0] xa, xd, input int xc, input logic xv,
                              input logic [31:0] xrd);
    vec_t v;
    v.en = en; v.we = we; v.addr = a; v.wdata = d; v.ack = ack; v.rdata = rd;
    v.x_stall = xs; v.x_req = xr; v.x_we = xw; v.x_addr = xa; v.x_wdata = xd;
    v.x_cnt = 3'(xc); v.x_rv = xv; v.x_rdata = xrd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, return at the falling edge for sampling.
  task automatic drive(input logic en, we, input logic [31:0] a, d, input logic ack,
                       input logic [31:0] rd);
    @(posedge clk);
    #1;
    bus.up_en = en; bus.up_wr_en = we; bus.up_addr = a; bus.up_wr_data = d;
    bus.l2_ack = ack; bus.l2_rdata = rd;
    @(negedge clk);
  endtask

  task automatic idle(input logic ack);
    drive(1'b0, 1'b0, 32'h0, 32'h0, ack, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.up_en = 1'b0; bus.up_wr_en = 1'b0; bus.up_addr = '0; bus.up_wr_data = '0;
    bus.l2_ack = 1'b0; bus.l2_rdata = '0;

    // Single store drain, empty-buffer read, fill-to-full with ordered drain and pointer wrap.
    tbl.push_back(mk(1,1,32'h100,32'hCAFE,0,0, 0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,             0,0,0,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,             0,1,1,32'h100,32'hCAFE,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,             0,1,1,32'h100,32'hCAFE,1,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,             0,1,1,32'h100,32'hCAFE,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,             0,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,32'h200,0,0,0,       1,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,32'h200,0,0,0,       1,1,0,32'h200,0,0,0,0));
    tbl.push_back(mk(1,0,32'h200,0,0,0,       1,1,0,32'h200,0,0,0,0));
    tbl.push_back(mk(1,0,32'h200,0,1,32'hBEEF,1,1,0,32'h200,0,0,0,0));
    tbl.push_back(mk(1,0,32'h200,0,0,0,       0,0,0,0,0,0,1,32'hBEEF));
    tbl.push_back(mk(0,0,0,0,0,0,             0,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,32'h10,32'hA1,0,0,   0,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,32'h14,32'hA2,0,0,   0,0,0,0,0,1,0,0));
    tbl.push_back(mk(1,1,32'h18,32'hA3,0,0,   0,1,1,32'h10,32'hA1,2,0,0));
    tbl.push_back(mk(1,1,32'h1C,32'hA4,0,0,   0,1,1,32'h10,32'hA1,3,0,0));
    tbl.push_back(mk(1,1,32'h20,32'hA5,0,0,   1,1,1,32'h10,32'hA1,4,0,0));
    tbl.push_back(mk(1,1,32'h20,32'hA5,0,0,   1,1,1,32'h10,32'hA1,4,0,0));
    tbl.push_back(mk(1,1,32'h20,32'hA5,1,0,   1,1,1,32'h10,32'hA1,4,0,0));
    tbl.push_back(mk(1,1,32'h20,32'hA5,0,0,   0,0,0,0,0,3,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,             0,1,1,32'h14,32'hA2,4,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,             0,1,1,32'h14,32'hA2,4,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,             0,0,0,0,0,3,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,             0,1,1,32'h18,32'hA3,3,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,             0,0,0,0,0,2,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,             0,1,1,32'h1C,32'hA4,2,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,             0,0,0,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,             0,1,1,32'h20,32'hA5,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,             0,0,0,0,0,0,0,0));

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req",    32'(bus.l2_req), 32'h0);
    chk("rst_we",     32'(bus.l2_we), 32'h0);
    chk("rst_addr",   bus.l2_addr, 32'h0);
    chk("rst_wdata",  bus.l2_wdata, 32'h0);
    chk("rst_rdata",  bus.up_rd_data, 32'h0);
    chk("rst_rvalid", 32'(bus.up_rd_valid), 32'h0);
    chk("rst_count",  32'(bus.wb_count), 32'h0);
    chk("rst_stall",  32'(bus.up_stall), 32'h0);

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].ack, tbl[i].rdata);
      chk($sformatf("v%0d_stall", i), 32'(bus.up_stall), 32'(tbl[i].x_stall));
      chk($sformatf("v%0d_req", i),   32'(bus.l2_req), 32'(tbl[i].x_req));
      chk($sformatf("v%0d_count", i), 32'(bus.wb_count), 32'(tbl[i].x_cnt));
      chk($sformatf("v%0d_rvalid", i), 32'(bus.up_rd_valid), 32'(tbl[i].x_rv));
      if (tbl[i].x_req) begin
        chk($sformatf("v%0d_we", i),   32'(bus.l2_we), 32'(tbl[i].x_we));
        chk($sformatf("v%0d_addr", i), bus.l2_addr, tbl[i].x_addr);
        if (tbl[i].x_we) chk($sformatf("v%0d_wdata", i), bus.l2_wdata, tbl[i].x_wdata);
      end
      if (tbl[i].x_rv) chk($sformatf("v%0d_rdata", i), bus.up_rd_data, tbl[i].x_rdata);
    end

    // Read-after-write to 0x300 with two queued stores.
    drive(1, 1, 32'h300, 32'h1, 0, 0);
    drive(1, 1, 32'h300, 32'h2, 0, 0);
    drive(1, 0, 32'h300, 32'h0, 0, 0);
    chk("raw_drain1_wdata", bus.l2_wdata, 32'h1);
    chk("raw_count2", 32'(bus.wb_count), 32'h2);
`ifdef WB_RAW_FWD_EN
    chk("raw_fwd_stall", 32'(bus.up_stall), 32'h0);
    chk("raw_fwd_rvalid", 32'(bus.up_rd_valid), 32'h1);
    chk("raw_fwd_rdata", bus.up_rd_data, 32'h2);
    idle(1);
    idle(0);
    chk("raw_fwd_req_gap", 32'(bus.l2_req), 32'h0);
    idle(1);
    chk("raw_fwd_drain2_we", 32'(bus.l2_we), 32'h1);
    chk("raw_fwd_drain2_wdata", bus.l2_wdata, 32'h2);
    idle(0);
    chk("raw_fwd_no_read", 32'(bus.l2_req), 32'h0);
    chk("raw_fwd_empty", 32'(bus.wb_count), 32'h0);
`else
    chk("raw_stall_a", 32'(bus.up_stall), 32'h1);
    drive(1, 0, 32'h300, 32'h0, 1, 0);
    drive(1, 0, 32'h300, 32'h0, 0, 0);
    chk("raw_stall_b", 32'(bus.up_stall), 32'h1);
    chk("raw_no_early_read", 32'(bus.l2_req), 32'h0);
    drive(1, 0, 32'h300, 32'h0, 1, 0);
    chk("raw_drain2_we", 32'(bus.l2_we), 32'h1);
    chk("raw_drain2_wdata", bus.l2_wdata, 32'h2);
    drive(1, 0, 32'h300, 32'h0, 0, 0);
    chk("raw_stall_c", 32'(bus.up_stall), 32'h1);
    chk("raw_empty", 32'(bus.wb_count), 32'h0);
    drive(1, 0, 32'h300, 32'h0, 1, 32'h77);
    chk("raw_read_we", 32'(bus.l2_we), 32'h0);
    chk("raw_read_addr", bus.l2_addr, 32'h300);
    drive(1, 0, 32'h300, 32'h0, 0, 0);
    chk("raw_rvalid", 32'(bus.up_rd_valid), 32'h1);
    chk("raw_rdata", bus.up_rd_data, 32'h77);
    chk("raw_release", 32'(bus.up_stall), 32'h0);
    idle(0);
`endif

    // Read to an unrelated address overtakes queued stores after the in-flight write.
    drive(1, 1, 32'h400, 32'hB1, 0, 0);
    drive(1, 1, 32'h400, 32'hB2, 0, 0);
    drive(1, 1, 32'h400, 32'hB3, 0, 0);
    drive(1, 0, 32'h500, 32'h0, 0, 0);
    chk("ovt_stall", 32'(bus.up_stall), 32'h1);
    chk("ovt_inflight", bus.l2_wdata, 32'hB1);
    drive(1, 0, 32'h500, 32'h0, 1, 0);
    drive(1, 0, 32'h500, 32'h0, 0, 0);
    chk("ovt_count", 32'(bus.wb_count), 32'h2);
    drive(1, 0, 32'h500, 32'h0, 0, 0);
    chk("ovt_read_req", 32'(bus.l2_req), 32'h1);
    chk("ovt_read_we", 32'(bus.l2_we), 32'h0);
    chk("ovt_read_addr", bus.l2_addr, 32'h500);
    drive(1, 0, 32'h500, 32'h0, 1, 32'hC5);
    drive(1, 0, 32'h500, 32'h0, 0, 0);
    chk("ovt_rdata", bus.up_rd_data, 32'hC5);
    chk("ovt_rvalid", 32'(bus.up_rd_valid), 32'h1);
    idle(0);
    idle(1);
    chk("ovt_drain_b2", bus.l2_wdata, 32'hB2);
    idle(0);
    idle(1);
    chk("ovt_drain_b3", bus.l2_wdata, 32'hB3);
    idle(0);
    chk("ovt_empty", 32'(bus.wb_count), 32'h0);

    // Reset while a drain is outstanding; the late ack must be ignored.
    drive(1, 1, 32'h600, 32'hD1, 0, 0);
    idle(0);
    idle(0);
    chk("rstmid_req_before", 32'(bus.l2_req), 32'h1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.l2_ack = 1'b1;
    @(negedge clk);
    chk("rstmid_req", 32'(bus.l2_req), 32'h0);
    chk("rstmid_count", 32'(bus.wb_count), 32'h0);
    idle(0);
    chk("rstmid_stray_req", 32'(bus.l2_req), 32'h0);
    chk("rstmid_stray_rvalid", 32'(bus.up_rd_valid), 32'h0);
    chk("rstmid_stray_count", 32'(bus.wb_count), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
